e_mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 55 +++++
 rtl/e_mdu_if.sv | 26 ++
 rtl/mdu_core.sv | 73 +++++++
 rtl/e_mdu.sv | 102 ++++++++++
 tb/tb_e_mdu.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the E-stage multiply/divide unit.
//   * mdu_op_e   : 4-bit MDUop encodings
//   * state_e    : IDLE / RUN control states
//   * defaults   : MULT_CYCLES_DEF / DIV_CYCLES_DEF latency constants
//   * helpers    : op_is_arith (ops that go through RUN), op_is_mul (ops that
//                  use the multiply latency)
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that use the multiplier array and its latency.
  function automatic logic op_is_mul(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops that produce a 64-bit result and hold the unit busy.
  function automatic logic op_is_arith(input logic [3:0] op);
    return op_is_mul(op) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// -----------------------------------------------------------------------------
// e_mdu_if -- E-stage <-> multiply/divide unit signal bundle.
//   start     : E-stage instruction valid and not stalled/flushed
//   MDUop     : operation code (mdu_pkg::mdu_op_e)
//   A, B      : forwarded rs / rt operands
//   busy      : arithmetic operation in flight
//   HILO_out  : HI when MDUop=MFHI, otherwise LO (combinational)
//   HI_out    : HI register
//   LO_out    : LO register
// Modports: master = pipeline side, slave = MDU side.
// -----------------------------------------------------------------------------
interface e_mdu_if;
  logic        start;
  logic [3:0]  MDUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HILO_out;
  logic [31:0] HI_out;
  logic [31:0] LO_out;

  modport master (output start, MDUop, A, B,
                  input  busy, HILO_out, HI_out, LO_out);
  modport slave  (input  start, MDUop, A, B,
                  output busy, HILO_out, HI_out, LO_out);
endinterface

// File: rtl/mdu_core.sv
// -----------------------------------------------------------------------------
// mdu_core -- combinational 64-bit result for the MDU.
//   op       : MDUop
//   a, b     : operands
//   acc      : {HI,LO} accumulator (only with MDU_MADD_EN)
//   result   : {HI,LO} value to commit at the end of RUN
//   div_zero : DIV/DIVU with b == 0 (operation must not start)
// Signed divide: quotient truncates toward zero, remainder takes the sign of
// the dividend; 0x80000000 / -1 yields LO=0x80000000, HI=0.
// -----------------------------------------------------------------------------
module mdu_core
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] a_s, b_s;
  logic        [63:0] smul, umul;
  logic               div_ovf;
  logic        [31:0] b_sdiv, b_udiv;
  logic signed [31:0] squo, srem;
  logic        [31:0] uquo, urem;

  assign a_s  = {{32{a[31]}}, a};
  assign b_s  = {{32{b[31]}}, b};
  assign smul = a_s * b_s;
  assign umul = {32'd0, a} * {32'd0, b};

  // The divider never sees a zero divisor or the overflowing signed pair;
  // both cases are resolved outside the divide.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_sdiv  = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
  assign b_udiv  = (b == 32'd0) ? 32'd1 : b;

  assign squo = $signed(a) / $signed(b_sdiv);
  assign srem = $signed(a) % $signed(b_sdiv);
  assign uquo = a / b_udiv;
  assign urem = a % b_udiv;

  always_comb begin
    // NOTE: every output gets a default before the case so no path holds an
    // old value, which would infer a latch.
    result   = '0;
    div_zero = 1'b0;
    case (op)
      OP_MULT:  result = smul;
      OP_MULTU: result = umul;
      OP_DIV: begin
        div_zero = (b == 32'd0);
        result   = div_ovf ? {32'd0, 32'h8000_0000} : {srem, squo};
      end
      OP_DIVU: begin
        div_zero = (b == 32'd0);
        result   = {urem, uquo};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = acc + smul;
      OP_MADDU: result = acc + umul;
      OP_MSUB:  result = acc - smul;
      OP_MSUBU: result = acc - umul;
`endif
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit; owns the architectural HI/LO.
// Parameters:
//   MULT_CYCLES : busy cycles for multiply-class ops (>=1)
//   DIV_CYCLES  : busy cycles for DIV/DIVU (>=1)
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-low; clears HI/LO, busy, counter, FSM
//   mdu   : e_mdu_if.slave (start, MDUop, A, B -> busy, HILO_out, HI_out,
//           LO_out)
// Behaviour: an arithmetic op accepted in IDLE computes its result at once
// into shadow registers, then holds busy for N cycles and commits to HI/LO on
// the edge where the counter reaches zero. MTHI/MTLO write in IDLE only.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU, multiply
// latency, accumulating onto HI/LO as sampled at the start edge).
// -----------------------------------------------------------------------------
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  mdu
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        hi, lo;
  logic [31:0]        res_hi, res_lo;
  logic               busy;

  logic [63:0]        core_result;
  logic               div_zero;
  logic               launch;
  logic [CNT_W-1:0]   op_cycles;

  mdu_core u_core (
    .op       (mdu.MDUop),
    .a        (mdu.A),
    .b        (mdu.B),
`ifdef MDU_MADD_EN
    .acc      ({hi, lo}),
`endif
    .result   (core_result),
    .div_zero (div_zero)
  );

  assign launch    = mdu.start && op_is_arith(mdu.MDUop) && !div_zero;
  assign op_cycles = op_is_mul(mdu.MDUop) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the values that were present before this edge.
      case (state)
        ST_IDLE: begin
          if (launch) begin
            res_hi <= core_result[63:32];
            res_lo <= core_result[31:0];
            cnt    <= op_cycles;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end else if (mdu.start && (mdu.MDUop == OP_MTHI)) begin
            hi <= mdu.A;
          end else if (mdu.start && (mdu.MDUop == OP_MTLO)) begin
            lo <= mdu.A;
          end
        end
        ST_RUN: begin
          // start is ignored here; the hazard unit never issues into RUN.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mdu.busy     = busy;
  assign mdu.HI_out   = hi;
  assign mdu.LO_out   = lo;
  assign mdu.HILO_out = (mdu.MDUop == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_e_mdu.sv
// -----------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu. Stimulus pushes expected HI/LO
// and busy length into a queue; a monitor pops and compares whenever busy
// falls. Expected values come from plain 64-bit arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  e_mdu_if mdu_bus ();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ref_hi   = '0;
  logic [31:0] ref_lo   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: new architectural {HI,LO} after the op, and whether the
  // op runs through the busy phase (with its length).
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       output bit arith, output logic [63:0] r, output int n);
    longint      sa, sb, q, rm;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {hi, lo};
    arith = 1'b0;
    r     = acc;
    n     = 0;
    case (op)
      OP_MULT:  begin arith = 1'b1; n = MC; r = 64'(sa * sb); end
      OP_MULTU: begin arith = 1'b1; n = MC; r = ua * ub; end
      OP_DIV: if (b != 0) begin
        arith = 1'b1; n = DC;
        q  = sa / sb;
        rm = sa % sb;
        r  = {rm[31:0], q[31:0]};
      end
      OP_DIVU: if (b != 0) begin
        arith = 1'b1; n = DC;
        r = {a % b, a / b};
      end
      OP_MTHI: r = {a, lo};
      OP_MTLO: r = {hi, a};
`ifdef MDU_MADD_EN
      OP_MADD:  begin arith = 1'b1; n = MC; r = acc + 64'(sa * sb); end
      OP_MADDU: begin arith = 1'b1; n = MC; r = acc + ua * ub; end
      OP_MSUB:  begin arith = 1'b1; n = MC; r = acc - 64'(sa * sb); end
      OP_MSUBU: begin arith = 1'b1; n = MC; r = acc - ua * ub; end
`endif
      default: r = acc;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge of the cycle in
  // which the next op may issue.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit          arith;
    logic [63:0] r;
    int          n;
    int          guard;
    model(op, a, b, ref_hi, ref_lo, arith, r, n);
    mdu_bus.start = 1'b1;
    mdu_bus.MDUop = op;
    mdu_bus.A     = a;
    mdu_bus.B     = b;
    if (arith) begin
      exp_q.push_back('{hi: r[63:32], lo: r[31:0], cycles: n});
    end else begin
      #1;
      check("hilo_out_mux", {32'd0, mdu_bus.HILO_out}, {32'd0, (op == OP_MFHI) ? ref_hi : ref_lo});
    end
    ref_hi = r[63:32];
    ref_lo = r[31:0];
    @(negedge clk);
    mdu_bus.start = 1'b0;
    mdu_bus.MDUop = OP_NONE;
    mdu_bus.A     = '0;
    mdu_bus.B     = '0;
    if (arith) begin
      guard = 0;
      while (mdu_bus.busy && guard < n + 4) begin
        @(negedge clk);
        guard++;
      end
      check("done_in_time", {63'd0, mdu_bus.busy}, 64'd0);
    end else begin
      check("idle_busy", {63'd0, mdu_bus.busy}, 64'd0);
      check("idle_hi", {32'd0, mdu_bus.HI_out}, {32'd0, ref_hi});
      check("idle_lo", {32'd0, mdu_bus.LO_out}, {32'd0, ref_lo});
    end
  endtask

  // Monitor: counts busy cycles and compares HI/LO when busy falls.
  int   run_cnt   = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      run_cnt   = 0;
      prev_busy = 1'b0;
    end else begin
      if (mdu_bus.busy) begin
        run_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("mon_hi", {32'd0, mdu_bus.HI_out}, {32'd0, mon_e.hi});
          check("mon_lo", {32'd0, mdu_bus.LO_out}, {32'd0, mon_e.lo});
          check("mon_busy_cycles", 64'(run_cnt), 64'(mon_e.cycles));
        end
        run_cnt = 0;
      end
      prev_busy = mdu_bus.busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0]  rand_ops[9] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI,
                                OP_MTLO, OP_MFHI, OP_MFLO, OP_NONE};
  bit          m_arith;
  logic [63:0] m_r;
  int          m_n;
  int          guard;
  bit          seen_busy;
  logic [31:0] ra, rb;

  initial begin
    mdu_bus.start = 1'b0;
    mdu_bus.MDUop = OP_NONE;
    mdu_bus.A     = '0;
    mdu_bus.B     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, mdu_bus.busy}, 64'd0);
    check("reset_hi", {32'd0, mdu_bus.HI_out}, 64'd0);
    check("reset_lo", {32'd0, mdu_bus.LO_out}, 64'd0);
    #2 reset = 1'b1;
    @(negedge clk);

    // Directed arithmetic, including back-to-back DIVU -> DIV.
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    do_op(OP_DIVU, 32'd100, 32'd7);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);

    // Zero divisor: nothing starts, HI/LO unchanged.
    do_op(OP_MTHI, 32'h11, 32'd0);
    do_op(OP_MTLO, 32'h22, 32'd0);
    do_op(OP_DIV, 32'd5, 32'd0);
    do_op(OP_DIVU, 32'd9, 32'd0);
    seen_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mdu_bus.busy) seen_busy = 1'b1;
    end
    check("div0_no_busy", {63'd0, seen_busy}, 64'd0);
    check("div0_hi", {32'd0, mdu_bus.HI_out}, 64'h11);
    check("div0_lo", {32'd0, mdu_bus.LO_out}, 64'h22);

    // MTHI then MFHI/MFLO reads.
    do_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    do_op(OP_MFHI, 32'd0, 32'd0);
    do_op(OP_MFLO, 32'd0, 32'd0);

    // Boundary operands.
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);

    // Starts during RUN are ignored (MTLO, DIV, MTHI while a MULT runs).
    model(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, ref_hi, ref_lo, m_arith, m_r, m_n);
    exp_q.push_back('{hi: m_r[63:32], lo: m_r[31:0], cycles: m_n});
    ref_hi = m_r[63:32];
    ref_lo = m_r[31:0];
    mdu_bus.start = 1'b1; mdu_bus.MDUop = OP_MULT; mdu_bus.A = 32'h1234_5678; mdu_bus.B = 32'h9ABC_DEF0;
    @(negedge clk);
    mdu_bus.MDUop = OP_MTLO; mdu_bus.A = 32'h5A5A_5A5A; mdu_bus.B = 32'd0;
    @(negedge clk);
    mdu_bus.MDUop = OP_DIV; mdu_bus.A = 32'd99; mdu_bus.B = 32'd3;
    @(negedge clk);
    mdu_bus.MDUop = OP_MTHI; mdu_bus.A = 32'hA5A5_A5A5;
    @(negedge clk);
    mdu_bus.start = 1'b0; mdu_bus.MDUop = OP_NONE; mdu_bus.A = '0; mdu_bus.B = '0;
    guard = 0;
    while (mdu_bus.busy && guard < int'(MC) + 4) begin
      @(negedge clk);
      guard++;
    end
    check("poke_done", {63'd0, mdu_bus.busy}, 64'd0);
    check("poke_hi", {32'd0, mdu_bus.HI_out}, {32'd0, ref_hi});
    check("poke_lo", {32'd0, mdu_bus.LO_out}, {32'd0, ref_lo});

    // NONE, accumulate-class and unused encodings.
    for (int op = 9; op < 16; op++) do_op(4'(op), $urandom, $urandom);
    do_op(OP_NONE, $urandom, $urandom);

`ifdef MDU_MADD_EN
    do_op(OP_MTHI, 32'd0, 32'd0);
    do_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    do_op(OP_MADDU, 32'd1, 32'd1);
    check("maddu_hi", {32'd0, mdu_bus.HI_out}, 64'd1);
    check("maddu_lo", {32'd0, mdu_bus.LO_out}, 64'd0);
    do_op(OP_MSUB, 32'd2, 32'hFFFF_FFFF);
`endif

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'(rb[7:0]);
      do_op(rand_ops[$urandom_range(0, 8)], ra, rb);
    end

    // Asynchronous reset in the middle of a DIV.
    do_op(OP_MTHI, 32'h77, 32'd0);
    do_op(OP_MTLO, 32'h88, 32'd0);
    mdu_bus.start = 1'b1; mdu_bus.MDUop = OP_DIV; mdu_bus.A = 32'd1000; mdu_bus.B = 32'd3;
    @(negedge clk);
    mdu_bus.start = 1'b0; mdu_bus.MDUop = OP_NONE; mdu_bus.A = '0; mdu_bus.B = '0;
    repeat (2) @(negedge clk);
    check("div_busy_before_reset", {63'd0, mdu_bus.busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_busy", {63'd0, mdu_bus.busy}, 64'd0);
    check("async_reset_hi", {32'd0, mdu_bus.HI_out}, 64'd0);
    check("async_reset_lo", {32'd0, mdu_bus.LO_out}, 64'd0);
    ref_hi = '0;
    ref_lo = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    seen_busy = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (mdu_bus.busy) seen_busy = 1'b1;
    end
    check("post_reset_no_busy", {63'd0, seen_busy}, 64'd0);
    check("post_reset_hi", {32'd0, mdu_bus.HI_out}, 64'd0);
    check("post_reset_lo", {32'd0, mdu_bus.LO_out}, 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
